// File: rtl/uge_hysteresis_detector.sv
// Streaming unsigned >= threshold detector with ON/OFF hysteresis and a saturating
// count of alarm rising edges.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | ALARM=0, no qualifying run in progress
//   S_ARMING  | ALARM=0, CNT consecutive valid GE samples seen so far
//   S_ACTIVE  | ALARM=1, last valid sample was GE
//   S_RELEASE | ALARM=1, CNT consecutive valid non-GE samples seen so far
module uge_hysteresis_detector #(
  parameter int WIDTH     = 4,
  parameter int ON_COUNT  = 3,
  parameter int OFF_COUNT = 2
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  input  logic             VALID,
  input  logic [WIDTH-1:0] THRESH,
  input  logic             CLR,
  output logic             GE,
  output logic             ALARM,
  output logic             RISE,
  output logic             FALL,
  output logic [7:0]       EVENTS
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMING  = 2'd1,
    S_ACTIVE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] ON_CNT  = ON_COUNT[7:0];
  localparam logic [7:0] OFF_CNT = OFF_COUNT[7:0];

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ge_q, ge_d;
  logic       alarm_q, alarm_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic [7:0] events_q, events_d;

  logic [WIDTH:0] sum_w;
  logic           ge_w;
  logic [7:0]     cnt_inc_w;

  // I >= THRESH is the carry-out of I + ~THRESH + 1, matching the UGE datapath.
  assign sum_w     = {1'b0, I} + {1'b0, ~THRESH} + {{WIDTH{1'b0}}, 1'b1};
  assign ge_w      = sum_w[WIDTH];
  assign cnt_inc_w = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ge_d    = ge_q;
    alarm_d = alarm_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (VALID) begin
      ge_d = ge_w;
      case (state_q)
        S_IDLE: begin
          if (ge_w) begin
            if (ON_CNT == 8'd1) begin
              state_d = S_ACTIVE;
              alarm_d = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = 8'd0;
            end else begin
              state_d = S_ARMING;
              cnt_d   = 8'd1;
            end
          end
        end
        S_ARMING: begin
          if (!ge_w) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else if (cnt_inc_w == ON_CNT) begin
            state_d = S_ACTIVE;
            alarm_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc_w;
          end
        end
        S_ACTIVE: begin
          if (!ge_w) begin
            if (OFF_CNT == 8'd1) begin
              state_d = S_IDLE;
              alarm_d = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = 8'd0;
            end else begin
              state_d = S_RELEASE;
              cnt_d   = 8'd1;
            end
          end
        end
        S_RELEASE: begin
          if (ge_w) begin
            state_d = S_ACTIVE;
            cnt_d   = 8'd0;
          end else if (cnt_inc_w == OFF_CNT) begin
            state_d = S_IDLE;
            alarm_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc_w;
          end
        end
        default: begin
          state_d = S_IDLE;
          alarm_d = 1'b0;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Clear wins first, then the same-edge rise is counted on top of it.
  always_comb begin
    events_d = events_q;
    if (CLR) begin
      events_d = {7'd0, rise_d};
    end else if (rise_d && (events_q != 8'hFF)) begin
      events_d = events_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      ge_q     <= 1'b0;
      alarm_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      events_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ge_q     <= ge_d;
      alarm_q  <= alarm_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      events_q <= events_d;
    end
  end

  assign GE     = ge_q;
  assign ALARM  = alarm_q;
  assign RISE   = rise_q;
  assign FALL   = fall_q;
  assign EVENTS = events_q;

endmodule

// File: tb/tb_uge_hysteresis_detector.sv
// Self-checking bench: directed boundary scenarios plus random traffic, compared
// against a run-length model of the hysteresis rules.
module tb_uge_hysteresis_detector;

  localparam int WIDTH     = 4;
  localparam int ON_COUNT  = 3;
  localparam int OFF_COUNT = 2;

  logic             CLK    = 1'b0;
  logic             RESETN = 1'b0;
  logic [WIDTH-1:0] I      = '0;
  logic             VALID  = 1'b0;
  logic [WIDTH-1:0] THRESH = '0;
  logic             CLR    = 1'b0;
  logic             GE, ALARM, RISE, FALL;
  logic [7:0]       EVENTS;

  always #5 CLK = ~CLK;

  uge_hysteresis_detector #(
    .WIDTH(WIDTH), .ON_COUNT(ON_COUNT), .OFF_COUNT(OFF_COUNT)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .I(I), .VALID(VALID), .THRESH(THRESH),
    .CLR(CLR), .GE(GE), .ALARM(ALARM), .RISE(RISE), .FALL(FALL), .EVENTS(EVENTS)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: lengths of the current GE / non-GE runs decide the alarm level.
  int m_ge, m_alarm, m_rise, m_fall, m_events;
  int run_ge, run_nge;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_ge = 0; m_alarm = 0; m_rise = 0; m_fall = 0; m_events = 0;
    run_ge = 0; run_nge = 0;
  endtask

  task automatic model_step();
    m_rise = 0;
    m_fall = 0;
    if (VALID) begin
      m_ge = (int'(I) >= int'(THRESH)) ? 1 : 0;
      if (m_ge == 1) begin run_ge++; run_nge = 0; end
      else           begin run_nge++; run_ge = 0; end
      if (m_alarm == 0 && run_ge >= ON_COUNT) begin
        m_alarm = 1; m_rise = 1;
      end else if (m_alarm == 1 && run_nge >= OFF_COUNT) begin
        m_alarm = 0; m_fall = 1;
      end
    end
    if (CLR) m_events = m_rise;
    else if (m_rise == 1 && m_events < 255) m_events++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ge"},     int'(GE),     m_ge);
    check({tag, ".alarm"},  int'(ALARM),  m_alarm);
    check({tag, ".rise"},   int'(RISE),   m_rise);
    check({tag, ".fall"},   int'(FALL),   m_fall);
    check({tag, ".events"}, int'(EVENTS), m_events);
  endtask

  task automatic tick(input string tag, input bit v, input int smp, input bit clr);
    VALID = v;
    I     = smp[WIDTH-1:0];
    CLR   = clr;
    @(posedge CLK);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ge"},     int'(GE),     0);
    check({tag, ".alarm"},  int'(ALARM),  0);
    check({tag, ".rise"},   int'(RISE),   0);
    check({tag, ".fall"},   int'(FALL),   0);
    check({tag, ".events"}, int'(EVENTS), 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    RESETN = 1'b1;

    // Rise exactly at the threshold boundary.
    THRESH = 4'd5;
    tick("rise0", 1, 5, 0);
    check("rise0.ge_const", int'(GE), 1);
    tick("rise1", 1, 6, 0);
    tick("rise2", 1, 15, 0);
    check("rise2.alarm_const", int'(ALARM), 1);
    check("rise2.rise_const", int'(RISE), 1);
    check("rise2.events_const", int'(EVENTS), 1);
    tick("rise3", 1, 15, 0);
    check("rise3.rise_pulse", int'(RISE), 0);

    // Release with hysteresis from ACTIVE.
    tick("rel0", 1, 4, 0);
    tick("rel1", 1, 9, 0);
    tick("rel2", 1, 4, 0);
    check("rel2.alarm_hold", int'(ALARM), 1);
    tick("rel3", 1, 0, 0);
    check("rel3.alarm_const", int'(ALARM), 0);
    check("rel3.fall_const", int'(FALL), 1);
    tick("rel4", 0, 0, 0);
    check("rel4.fall_pulse", int'(FALL), 0);

    // Broken run restarts counting.
    tick("brk0", 1, 5, 0);
    tick("brk1", 1, 6, 0);
    tick("brk2", 1, 4, 0);
    tick("brk3", 1, 7, 0);
    tick("brk4", 1, 8, 0);
    check("brk4.alarm_const", int'(ALARM), 0);
    tick("brk5", 1, 9, 0);
    check("brk5.alarm_const", int'(ALARM), 1);
    tick("brk6", 1, 0, 0);
    tick("brk7", 1, 0, 0);

    // Idle cycles between valid samples hold the run.
    tick("gap0", 1, 7, 0);
    tick("gap1", 0, 0, 0);
    tick("gap2", 0, 0, 0);
    tick("gap3", 1, 7, 0);
    check("gap3.alarm_const", int'(ALARM), 0);
    tick("gap4", 1, 7, 0);
    check("gap4.alarm_const", int'(ALARM), 1);
    tick("gap5", 1, 0, 0);
    tick("gap6", 1, 0, 0);

    // Compare extremes.
    THRESH = 4'd0;
    tick("ext0", 1, 0, 0);
    check("ext0.ge_const", int'(GE), 1);
    THRESH = 4'd15;
    tick("ext1", 1, 15, 0);
    check("ext1.ge_const", int'(GE), 1);
    tick("ext2", 1, 14, 0);
    check("ext2.ge_const", int'(GE), 0);
    tick("ext3", 1, 0, 0);
    tick("ext4", 1, 0, 0);

    // Saturate the event counter.
    THRESH = 4'd8;
    for (int n = 0; n < 256; n++) begin
      for (int k = 0; k < ON_COUNT; k++)  tick("sat_on", 1, 10, 0);
      for (int k = 0; k < OFF_COUNT; k++) tick("sat_off", 1, 1, 0);
    end
    check("sat.events_const", int'(EVENTS), 255);

    // Clear on the same edge as a rise.
    tick("clr0", 1, 10, 0);
    tick("clr1", 1, 10, 0);
    tick("clr2", 1, 10, 1);
    check("clr2.events_const", int'(EVENTS), 1);
    tick("clr3", 1, 1, 0);
    tick("clr4", 1, 1, 0);

    // Random traffic, including mid-run threshold changes.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) THRESH = WIDTH'($urandom_range(0, 15));
      tick("rnd", $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset while ALARM is high.
    THRESH = 4'd0;
    for (int k = 0; k < ON_COUNT + 1; k++) tick("pre_rst", 1, 3, 0);
    check("pre_rst.alarm_const", int'(ALARM), 1);
    RESETN = 1'b0;
    #1;
    model_reset();
    check_zero("async_rst");
    @(posedge CLK);
    #1;
    check_zero("rst_hold");
    RESETN = 1'b1;
    tick("post_rst", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
